// File: rtl/unified_mem_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | unified_mem_arb_pkg : shared state encoding and widths for the arbiter     |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
package unified_mem_arb_pkg;

  localparam int DEFAULT_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_ARB   = 2'd0,
    ST_DATA  = 2'd1,
    ST_FETCH = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

endpackage : unified_mem_arb_pkg
`default_nettype wire

// File: rtl/unified_mem_arbiter_sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sat_counter : enable-gated up counter that sticks at all-ones              |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] C_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (en && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + C_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule : sat_counter
`default_nettype wire

// File: rtl/unified_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | unified_mem_arbiter : serialises MEM-stage data access then IF fetch       |
// | onto one single-ported memory, freezing the pipeline until both are done.  |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module unified_mem_arbiter
  import unified_mem_arb_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] inst_adr,
  output logic [DATA_W-1:0] inst,
  input  logic [DATA_W-1:0] data_adr,
  input  logic [DATA_W-1:0] data_out,
  input  logic              mem_read,
  input  logic              mem_write,
  output logic [DATA_W-1:0] data_in,
  output logic              stall,
  output logic [DATA_W-1:0] m_adr,
  output logic [DATA_W-1:0] m_wdata,
  output logic              m_req,
  output logic              m_we,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ack,
  output logic [CNT_W-1:0]  stall_cnt
);

  arb_state_e        state_q, state_d;
  logic [DATA_W-1:0] inst_buf_q, inst_buf_d;
  logic [DATA_W-1:0] rdata_buf_q, rdata_buf_d;

  always_comb begin
    state_d     = state_q;
    inst_buf_d  = inst_buf_q;
    rdata_buf_d = rdata_buf_q;
    stall       = 1'b1;
    m_req       = 1'b0;
    m_we        = 1'b0;
    m_adr       = '0;
    m_wdata     = '0;

    case (state_q)
      ST_ARB: begin
        state_d = (mem_read || mem_write) ? ST_DATA : ST_FETCH;
      end

      ST_DATA: begin
        m_req   = 1'b1;
        m_adr   = data_adr;
        m_wdata = data_out;
        m_we    = mem_write;
        if (m_ack) begin
          // A simultaneous read+write request is carried out as a store only
          if (mem_read && !mem_write) begin
            rdata_buf_d = m_rdata;
          end
          state_d = ST_FETCH;
        end
      end

      ST_FETCH: begin
        m_req = 1'b1;
        m_adr = inst_adr;
        if (m_ack) begin
          inst_buf_d = m_rdata;
          state_d    = ST_DONE;
        end
      end

      ST_DONE: begin
        stall   = 1'b0;
        state_d = ST_ARB;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ARB;
      inst_buf_q  <= '0;
      rdata_buf_q <= '0;
    end else begin
      state_q     <= state_d;
      inst_buf_q  <= inst_buf_d;
      rdata_buf_q <= rdata_buf_d;
    end
  end

  assign inst    = inst_buf_q;
  assign data_in = rdata_buf_q;

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (stall),
    .count (stall_cnt)
  );

endmodule : unified_mem_arbiter
`default_nettype wire

// File: tb/tb_unified_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_unified_mem_arbiter : window-level reference model plus directed cases  |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_unified_mem_arbiter;

  localparam int C_DW = 32;
  localparam int C_CW = 4;

  logic            clk;
  logic            rst;
  logic [C_DW-1:0] inst_adr, inst, data_adr, data_out, data_in;
  logic            mem_read, mem_write, stall;
  logic [C_DW-1:0] m_adr, m_wdata, m_rdata;
  logic            m_req, m_we, m_ack;
  logic [C_CW-1:0] stall_cnt;

  unified_mem_arbiter #(
    .DATA_W (C_DW),
    .CNT_W  (C_CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .inst_adr  (inst_adr),
    .inst      (inst),
    .data_adr  (data_adr),
    .data_out  (data_out),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .data_in   (data_in),
    .stall     (stall),
    .m_adr     (m_adr),
    .m_wdata   (m_wdata),
    .m_req     (m_req),
    .m_we      (m_we),
    .m_rdata   (m_rdata),
    .m_ack     (m_ack),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Memory as seen by the bus responder, and the model's own view of it
  logic [31:0] phys_mem [logic [31:0]];
  logic [31:0] ref_mem  [logic [31:0]];

  function automatic logic [31:0] phys_rd(input logic [31:0] a);
    return phys_mem.exists(a) ? phys_mem[a] : (a ^ 32'hA5A5_0000);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : (a ^ 32'hA5A5_0000);
  endfunction

  // Bus responder: acks the L-th cycle after a request starts
  int   lat        = 1;
  int   age        = 0;
  logic inject_ack = 1'b0;
  logic prev_ack;

  always @(posedge clk) begin
    #1;
    if (inject_ack) begin
      m_ack      = 1'b1;
      m_rdata    = 32'hBAD0_BAD0;
      inject_ack = 1'b0;
      age        = 0;
    end else if (rst) begin
      m_ack = 1'b0;
      age   = 0;
    end else begin
      prev_ack = m_ack;
      m_ack    = 1'b0;
      if (!m_req || prev_ack) age = 0;
      if (m_req) begin
        if (age == lat) begin
          m_ack = 1'b1;
          if (m_we) phys_mem[m_adr] = m_wdata;
          else      m_rdata = phys_rd(m_adr);
        end
        age++;
      end
    end
  end

  // Expected per-cycle outputs, built one whole window at a time
  typedef struct {
    logic        stall;
    logic        req;
    logic        we;
    logic [31:0] adr;
    logic [31:0] wdata;
    logic [31:0] inst;
    logic [31:0] din;
    logic [3:0]  cnt;
  } exp_t;

  exp_t        expq[$];
  exp_t        cur;
  logic [31:0] exp_inst = '0;
  logic [31:0] exp_data = '0;
  int          exp_cnt  = 0;

  function automatic void push_exp(input logic s, input logic r, input logic w,
                                   input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    e.stall = s;  e.req = r;  e.we = w;  e.adr = a;  e.wdata = wd;
    e.inst  = exp_inst;
    e.din   = exp_data;
    e.cnt   = (exp_cnt > 15) ? 4'hF : exp_cnt[3:0];
    if (s) exp_cnt++;
    expq.push_back(e);
  endfunction

  always @(negedge clk) begin
    if (expq.size() > 0) begin
      cur = expq.pop_front();
      check("stall", stall, cur.stall);
      check("m_req", m_req, cur.req);
      if (cur.req) begin
        check("m_adr", m_adr, cur.adr);
        check("m_we", m_we, cur.we);
        check("m_wdata", m_wdata, cur.wdata);
      end
      check("inst", inst, cur.inst);
      check("data_in", data_in, cur.din);
      check("stall_cnt", stall_cnt, cur.cnt);
    end
  end

  task automatic run_window(input int L, input logic [31:0] ia, input logic [31:0] da,
                            input logic [31:0] dout, input logic rd, input logic wr,
                            input int exp_len);
    int n;
    lat       = L;
    inst_adr  = ia;
    data_adr  = da;
    data_out  = dout;
    mem_read  = rd;
    mem_write = wr;
    push_exp(1'b1, 1'b0, 1'b0, '0, '0);
    if (rd || wr) begin
      repeat (L + 1) push_exp(1'b1, 1'b1, wr, da, dout);
      if (wr) ref_mem[da] = dout;
      else    exp_data    = ref_rd(da);
    end
    repeat (L + 1) push_exp(1'b1, 1'b1, 1'b0, ia, '0);
    exp_inst = ref_rd(ia);
    push_exp(1'b0, 1'b0, 1'b0, '0, '0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (stall !== 1'b0 && n < 64);
    check("window_len", n, exp_len);
    if (n >= 64) expq.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    expq.delete();
    @(posedge clk);
    #2;
    check("rst_stall", stall, 1'b1);
    check("rst_m_req", m_req, 1'b0);
    check("rst_inst", inst, 32'h0);
    check("rst_data_in", data_in, 32'h0);
    check("rst_stall_cnt", stall_cnt, 4'h0);
    rst      = 1'b0;
    exp_inst = '0;
    exp_data = '0;
    exp_cnt  = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;  inst_adr = '0;  data_adr = '0;  data_out = '0;
    mem_read = 1'b0;  mem_write = 1'b0;  m_ack = 1'b0;  m_rdata = '0;

    phys_mem[32'h00] = 32'h2008_0005;  ref_mem[32'h00] = 32'h2008_0005;
    phys_mem[32'h08] = 32'h8C09_0040;  ref_mem[32'h08] = 32'h8C09_0040;
    phys_mem[32'h40] = 32'hDEAD_BEEF;  ref_mem[32'h40] = 32'hDEAD_BEEF;
    phys_mem[32'h10] = 32'h0000_0013;  ref_mem[32'h10] = 32'h0000_0013;

    // Out of reset, fetch-only window with one-cycle memory
    do_reset();
    run_window(1, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 4);
    check("first_inst", inst, 32'h2008_0005);
    check("first_stall_cnt", stall_cnt, 4'd3);

    // Load window
    run_window(1, 32'h8, 32'h40, 32'h0, 1'b1, 1'b0, 6);
    check("load_data_in", data_in, 32'hDEAD_BEEF);
    check("load_inst", inst, 32'h8C09_0040);

    // Store window: load result must persist
    run_window(1, 32'h0C, 32'h44, 32'h1234_5678, 1'b0, 1'b1, 6);
    check("store_keeps_data_in", data_in, 32'hDEAD_BEEF);

    // Five-cycle memory latency, fetch-only; counter is saturated by now
    run_window(5, 32'h08, 32'h0, 32'h0, 1'b0, 1'b0, 8);
    check("wait_inst", inst, 32'h8C09_0040);
    check("sat_stall_cnt", stall_cnt, 4'hF);

    // Read and write together act as a store
    run_window(2, 32'h00, 32'h48, 32'hCAFE_F00D, 1'b1, 1'b1, 8);
    check("conflict_data_in", data_in, 32'hDEAD_BEEF);

    // Read back the earlier store
    run_window(1, 32'h00, 32'h44, 32'h0, 1'b1, 1'b0, 6);
    check("readback_data_in", data_in, 32'h1234_5678);

    // Reset in the middle of a pending store, with a stray ack afterwards
    lat = 3;  inst_adr = 32'h10;  data_adr = 32'h50;  data_out = 32'h55AA_55AA;
    mem_read = 1'b0;  mem_write = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2;
    check("abort_m_req", m_req, 1'b1);
    check("abort_m_we", m_we, 1'b1);
    check("abort_m_adr", m_adr, 32'h50);
    inject_ack = 1'b1;
    do_reset();
    run_window(1, 32'h10, 32'h0, 32'h0, 1'b0, 1'b0, 4);
    check("post_rst_inst", inst, 32'h0000_0013);
    check("post_rst_data_in", data_in, 32'h0);
    check("post_rst_stall_cnt", stall_cnt, 4'd3);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_unified_mem_arbiter
`default_nettype wire

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-ported unified instruction/data memory between the pipeline's IF stage (instruction fetch) and MEM stage (data load/store).
- Per pipeline advance ("window"), serves the data access first (if any), then the instruction fetch. Holds `stall` high until both have completed.
- Sits between the pipelined datapath (inst_adr/inst, data_adr/data_out/data_in, mem_read/mem_write) and the memory's req/ack port.
- Top level ANDs `~stall` into every pipeline-register load and into pc_load.

Parameters:
- DATA_W, 32, width of addresses, instruction words and data words
- CNT_W, 32, width of the saturating stall-cycle counter

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- inst_adr  in  DATA_W  fetch address (PC)
- inst  out  DATA_W  fetched instruction, valid when stall=0
- data_adr  in  DATA_W  MEM-stage address
- data_out  in  DATA_W  MEM-stage store data
- mem_read  in  1  MEM-stage load request
- mem_write  in  1  MEM-stage store request
- data_in  out  DATA_W  load result, valid when stall=0
- stall  out  1  pipeline freeze; 0 for exactly one cycle per completed window
- m_adr  out  DATA_W  memory address
- m_wdata  out  DATA_W  memory write data
- m_req  out  1  memory request
- m_we  out  1  memory write enable, qualified by m_req
- m_rdata  in  DATA_W  memory read data, valid with m_ack
- m_ack  in  1  single-cycle completion pulse, at least 1 cycle after m_req rises
- stall_cnt  out  CNT_W  count of cycles with stall=1, saturating at all-ones

Behaviour:
- Registered FSM with states ARB, DATA, FETCH, DONE.
- **Reset** (any cycle, including mid-access):
  - state=ARB; inst_buf=0; rdata_buf=0; stall_cnt=0.
  - m_req drops in the cycle after the reset edge. An m_ack arriving after reset is ignored.
- **Output decode** (combinational from state):
  - stall=1 in every state except DONE.
  - m_req=1 only in DATA or FETCH.
  - inst=inst_buf and data_in=rdata_buf at all times.
- **ARB:**
  - If mem_read|mem_write, go to DATA; otherwise go to FETCH.
  - No memory request is issued in ARB.
- **DATA:**
  - m_adr=data_adr; m_wdata=data_out; m_we=mem_write.
  - If mem_read and mem_write are both 1, the access is a write and rdata_buf is unchanged.
  - On m_ack: if it was a read, capture rdata_buf<=m_rdata; then go to FETCH.
  - For a store, rdata_buf is unchanged.
- **FETCH:**
  - m_adr=inst_adr; m_we=0; m_wdata=don't-care (driven 0).
  - On m_ack: capture inst_buf<=m_rdata, then go to DONE.
- **DONE:**
  - stall=0 for one cycle, during which the pipeline advances at the clock edge.
  - Next state is ARB.
- **Request rules:**
  - m_adr, m_we and m_wdata are stable while m_req=1 and m_ack=0.
  - A DATA→FETCH transition may keep m_req high with a new address. The memory treats a cycle with m_req=1 following an ack as a new request.
- **Datapath hold:** all datapath inputs are stable while stall=1, because the pipeline is frozen. The arbiter samples them combinationally each cycle.
- **Window latency** (memory acks L cycles after req, L≥1):
  - Fetch-only window: 1 + L + 1 + 1 = L+3 cycles from ARB to DONE inclusive.
  - Fetch+data window: 2L+4 cycles.
- **stall_cnt:** +1 every cycle with stall=1; holds at 2^CNT_W−1; cleared only by rst.
- **Out of reset:** stall=1 until the first fetch completes, so the pipeline never executes inst_buf's reset value.
- An m_ack pulse in ARB or DONE is illegal and ignored; no state or buffer changes.

Decomposition:
- Shared package unified_mem_arb_pkg holds:
  - the state encoding (ARB=2'd0, DATA=2'd1, FETCH=2'd2, DONE=2'd3);
  - the default DATA_W.
- One natural sub-module: sat_counter (parameter CNT_W; ports clk, rst, en, count) for stall_cnt.
- FSM, address/write mux and capture buffers stay in unified_mem_arbiter.

Test Plan:
- **Reset, then fetch-only.** Stimulus: rst pulse, then inst_adr=0x0, mem_read=mem_write=0; memory acks 1 cycle after req with m_rdata=0x20080005. Required: m_req rises in cycle 2 with m_adr=0x0, m_we=0; stall=0 exactly in cycle 4 with inst=0x20080005; stall_cnt=3.
- **Load window.** Stimulus: mem_read=1, data_adr=0x40, inst_adr=0x8; memory returns 0xDEADBEEF for 0x40 and 0x8C090040 for 0x8, L=1. Required: the first request is m_adr=0x40 m_we=0, the second m_adr=0x8; at DONE, data_in=0xDEADBEEF and inst=0x8C090040; window length 6 cycles.
- **Store window.** Stimulus: mem_write=1, data_adr=0x44, data_out=0x12345678. Required: first request m_we=1, m_wdata=0x12345678; data_in keeps its previous value; then a fetch request with m_we=0.
- **Wait states.** Stimulus: memory acks 5 cycles after req. Required: m_adr, m_we and m_wdata hold stable for all 5 cycles; stall stays high until DONE; fetch-only window is 8 cycles.
- **Reset mid-access.** Stimulus: assert rst during DATA with a pending store, then ack on the following cycle. Required: m_req=0 after the reset edge; buffers and stall_cnt read 0; the late ack causes no capture; the next request issued is a fetch.
- **Conflicting and saturating cases.** Stimulus: mem_read=mem_write=1; separately, CNT_W=4 with a long stall. Required: the access is treated as a write and rdata_buf is unchanged; stall_cnt stops at 4'hF.
